hi_reader_mode_ctrl: RTL and testbench

Sequencer that owns the HF reader datapath's `minor_mode` and `subcarrier_frequency` inputs.
- Accepts mode-change commands from the ARM-side register interface through a valid/ready handshake.
- Applies each change only on a correlator frame boundary, so a 64-sample I/Q frame is never split across modes.
- Enforces a settle interval after transmit-to-receive switches, and times out jam bursts.
- Sits between the SSP/config decode logic and the HF reader datapath.

---
 rtl/hi_reader_pkg.sv | 39 +++
 rtl/hi_reader_frame_counter.sv | 32 +++
 rtl/hi_reader_mode_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_hi_reader_mode_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hi_reader_pkg.sv
// Shared encodings, mode-class predicates and sequencer state enum for the HF reader.
// Single source of mode/subcarrier constants for hi_reader decode and hi_reader_mode_ctrl.
package hi_reader_pkg;

  localparam logic [3:0] MODE_RECEIVE_IQ        = 4'd0;
  localparam logic [3:0] MODE_RECEIVE_AMPLITUDE = 4'd1;
  localparam logic [3:0] MODE_RECEIVE_PHASE     = 4'd2;
  localparam logic [3:0] MODE_SEND_FULL_MOD     = 4'd3;
  localparam logic [3:0] MODE_SEND_SHALLOW_MOD  = 4'd4;
  localparam logic [3:0] MODE_SNIFF_IQ          = 4'd5;
  localparam logic [3:0] MODE_SNIFF_AMPLITUDE   = 4'd6;
  localparam logic [3:0] MODE_SNIFF_PHASE       = 4'd7;
  localparam logic [3:0] MODE_SEND_JAM          = 4'd8;

  localparam logic [1:0] SUBCARRIER_848_KHZ = 2'd0;
  localparam logic [1:0] SUBCARRIER_424_KHZ = 2'd1;
  localparam logic [1:0] SUBCARRIER_212_KHZ = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_JAM    = 2'd3
  } mode_state_e;

  function automatic logic mode_is_send(input logic [3:0] mode);
    return (mode == MODE_SEND_FULL_MOD) || (mode == MODE_SEND_SHALLOW_MOD) ||
           (mode == MODE_SEND_JAM);
  endfunction

  function automatic logic mode_is_rx(input logic [3:0] mode);
    return (mode <= MODE_SNIFF_PHASE) && !mode_is_send(mode);
  endfunction

  function automatic logic mode_is_legal(input logic [3:0] mode);
    return (mode <= MODE_SEND_JAM);
  endfunction

endpackage

// File: rtl/hi_reader_frame_counter.sv
// Loadable saturating down-counter advanced by frame_tick; expire fires on the
// tick that takes it from 1 to 0.
module hi_reader_frame_counter #(
  parameter int W         = 4,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] count_r;

  // Count register: load wins over tick, holds at zero.
  always_ff @(negedge clk) begin
    if (reset) begin
      count_r <= W'(RESET_VAL);
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = tick && !load && (count_r == W'(1));

endmodule

// File: rtl/hi_reader_mode_ctrl.sv
// Frame-aligned minor_mode / subcarrier sequencer for the HF reader datapath.
// Optional jam timeout is built when HI_READER_JAM_TIMEOUT_EN is defined.
module hi_reader_mode_ctrl
  import hi_reader_pkg::*;
#(
  parameter int SETTLE_FRAMES = 4,
  parameter int TIMEOUT_W     = 12
) (
  input  logic                 ck_1356meg,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_mode,
  input  logic [1:0]           cmd_subcarrier,
  input  logic [TIMEOUT_W-1:0] cmd_frames,
  output logic [3:0]           minor_mode,
  output logic [1:0]           subcarrier_frequency,
  output logic                 rx_valid,
  output logic                 mode_update,
  output logic                 jam_done,
  output logic                 cmd_err
);

  localparam int SETTLE_W  = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam bit SETTLE_EN = (SETTLE_FRAMES != 0);

  mode_state_e state_r, state_s;
  logic [3:0]  mode_r, mode_s, pend_mode_r, pend_mode_s;
  logic [1:0]  sub_r, sub_s, pend_sub_r, pend_sub_s;
  logic        rx_valid_r, cmd_ready_r, mode_update_r, cmd_err_r;
  logic        mode_update_s, cmd_err_s;
  logic        accept_s, legal_s;
  logic        settle_load_s, settle_tick_s, settle_expire_s;

  assign accept_s      = cmd_valid && cmd_ready_r;
  assign legal_s       = mode_is_legal(cmd_mode);
  assign settle_tick_s = frame_tick && (state_r == ST_SETTLE);

  hi_reader_frame_counter #(
    .W         (SETTLE_W),
    .RESET_VAL (SETTLE_FRAMES)
  ) u_settle_cnt (
    .clk      (ck_1356meg),
    .reset    (reset),
    .load     (settle_load_s),
    .load_val (SETTLE_W'(SETTLE_FRAMES)),
    .tick     (settle_tick_s),
    .expire   (settle_expire_s)
  );

`ifdef HI_READER_JAM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] pend_frames_r, pend_frames_s;
  logic [3:0]           save_mode_r, save_mode_s;
  logic [1:0]           save_sub_r, save_sub_s;
  logic                 jam_load_s, jam_tick_s, jam_expire_s, jam_done_s, jam_done_r;

  assign jam_tick_s = frame_tick && (state_r == ST_JAM);

  hi_reader_frame_counter #(
    .W         (TIMEOUT_W),
    .RESET_VAL (0)
  ) u_jam_cnt (
    .clk      (ck_1356meg),
    .reset    (reset),
    .load     (jam_load_s),
    .load_val (pend_frames_r),
    .tick     (jam_tick_s),
    .expire   (jam_expire_s)
  );

  // Jam bookkeeping: frame budget of the pending command and the mode to restore.
  always_ff @(negedge ck_1356meg) begin
    if (reset) begin
      pend_frames_r <= '0;
      save_mode_r   <= MODE_RECEIVE_IQ;
      save_sub_r    <= SUBCARRIER_848_KHZ;
      jam_done_r    <= 1'b0;
    end else begin
      pend_frames_r <= pend_frames_s;
      save_mode_r   <= save_mode_s;
      save_sub_r    <= save_sub_s;
      jam_done_r    <= jam_done_s;
    end
  end

  assign jam_done = jam_done_r;
`else
  logic unused_cmd_frames_s;
  assign unused_cmd_frames_s = ^cmd_frames;
  assign jam_done            = 1'b0;
`endif

  // Next-state and output decode; apply happens only on frame_tick.
  always_comb begin
    state_s       = state_r;
    mode_s        = mode_r;
    sub_s         = sub_r;
    pend_mode_s   = pend_mode_r;
    pend_sub_s    = pend_sub_r;
    settle_load_s = 1'b0;
    mode_update_s = 1'b0;
    cmd_err_s     = accept_s && !legal_s;
`ifdef HI_READER_JAM_TIMEOUT_EN
    pend_frames_s = pend_frames_r;
    save_mode_s   = save_mode_r;
    save_sub_s    = save_sub_r;
    jam_load_s    = 1'b0;
    jam_done_s    = 1'b0;
`endif
    case (state_r)
      ST_RUN: begin
        if (accept_s && legal_s) begin
          pend_mode_s = cmd_mode;
          pend_sub_s  = cmd_subcarrier;
`ifdef HI_READER_JAM_TIMEOUT_EN
          pend_frames_s = cmd_frames;
`endif
          state_s = ST_PEND;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PEND: begin
        if (frame_tick) begin
          mode_s        = pend_mode_r;
          sub_s         = pend_sub_r;
          mode_update_s = 1'b1;
          if (SETTLE_EN && mode_is_send(mode_r) && mode_is_rx(pend_mode_r)) begin
            state_s       = ST_SETTLE;
            settle_load_s = 1'b1;
          end
`ifdef HI_READER_JAM_TIMEOUT_EN
          else if ((pend_mode_r == MODE_SEND_JAM) && (pend_frames_r != '0)) begin
            state_s     = ST_JAM;
            jam_load_s  = 1'b1;
            save_mode_s = mode_r;
            save_sub_s  = sub_r;
          end
`endif
          else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_PEND;
        end
      end
      ST_SETTLE: begin
        if (settle_expire_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_JAM: begin
`ifdef HI_READER_JAM_TIMEOUT_EN
        // A new legal command cancels the timer outright, even on an expiry tick.
        if (accept_s && legal_s) begin
          pend_mode_s   = cmd_mode;
          pend_sub_s    = cmd_subcarrier;
          pend_frames_s = cmd_frames;
          state_s       = ST_PEND;
        end else if (jam_expire_s) begin
          mode_s        = save_mode_r;
          sub_s         = save_sub_r;
          jam_done_s    = 1'b1;
          mode_update_s = 1'b1;
          if (SETTLE_EN && mode_is_rx(save_mode_r)) begin
            state_s       = ST_SETTLE;
            settle_load_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_JAM;
        end
`else
        state_s = ST_RUN;
`endif
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Main state and registered datapath-facing outputs.
  always_ff @(negedge ck_1356meg) begin
    if (reset) begin
      state_r       <= SETTLE_EN ? ST_SETTLE : ST_RUN;
      mode_r        <= MODE_RECEIVE_IQ;
      sub_r         <= SUBCARRIER_848_KHZ;
      pend_mode_r   <= MODE_RECEIVE_IQ;
      pend_sub_r    <= SUBCARRIER_848_KHZ;
      rx_valid_r    <= 1'b0;
      cmd_ready_r   <= !SETTLE_EN;
      mode_update_r <= 1'b0;
      cmd_err_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      mode_r        <= mode_s;
      sub_r         <= sub_s;
      pend_mode_r   <= pend_mode_s;
      pend_sub_r    <= pend_sub_s;
      rx_valid_r    <= mode_is_rx(mode_s) && (state_s != ST_SETTLE);
      cmd_ready_r   <= (state_s == ST_RUN) || (state_s == ST_JAM);
      mode_update_r <= mode_update_s;
      cmd_err_r     <= cmd_err_s;
    end
  end

  assign minor_mode           = mode_r;
  assign subcarrier_frequency = sub_r;
  assign rx_valid             = rx_valid_r;
  assign cmd_ready            = cmd_ready_r;
  assign mode_update          = mode_update_r;
  assign cmd_err              = cmd_err_r;

endmodule

// File: tb/tb_hi_reader_mode_ctrl.sv
// Directed self-checking bench for hi_reader_mode_ctrl (SETTLE_FRAMES=4, TIMEOUT_W=12).
// Jam expectations follow HI_READER_JAM_TIMEOUT_EN when it is defined.
module tb_hi_reader_mode_ctrl;

  logic        ck_1356meg = 1'b0;
  logic        reset, frame_tick, cmd_valid, cmd_ready;
  logic [3:0]  cmd_mode, minor_mode;
  logic [1:0]  cmd_subcarrier, subcarrier_frequency;
  logic [11:0] cmd_frames;
  logic        rx_valid, mode_update, jam_done, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;

  hi_reader_mode_ctrl #(.SETTLE_FRAMES(4), .TIMEOUT_W(12)) dut (
    .ck_1356meg           (ck_1356meg),
    .reset                (reset),
    .frame_tick           (frame_tick),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_mode             (cmd_mode),
    .cmd_subcarrier       (cmd_subcarrier),
    .cmd_frames           (cmd_frames),
    .minor_mode           (minor_mode),
    .subcarrier_frequency (subcarrier_frequency),
    .rx_valid             (rx_valid),
    .mode_update          (mode_update),
    .jam_done             (jam_done),
    .cmd_err              (cmd_err)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  // One negedge; frame_tick mirrors a 64-count correlator with tick at phase 0.
  task automatic step();
    frame_tick = (phase == 0);
    @(negedge ck_1356meg);
    #2;
    phase = (phase + 1) % 64;
  endtask

  task automatic goto_phase(input int p);
    while (phase != p) step();
  endtask

  task automatic apply_tick();
    goto_phase(0);
    step();
  endtask

  task automatic issue(input logic [3:0] m, input logic [1:0] s, input logic [11:0] f);
    cmd_valid      = 1'b1;
    cmd_mode       = m;
    cmd_subcarrier = s;
    cmd_frames     = f;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL rst_mode: got %0d want 0", minor_mode); end
    n_checks++; if (subcarrier_frequency !== 2'd0) begin n_fail++; $display("FAIL rst_sub: got %0d want 0", subcarrier_frequency); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b want 0", cmd_ready); end
    n_checks++; if ({mode_update, jam_done, cmd_err} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b want 000", {mode_update, jam_done, cmd_err}); end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      apply_tick();
      n_checks++; if (rx_valid !== (k == 4)) begin n_fail++; $display("FAIL rst_settle_rxv tick%0d: got %b want %b", k, rx_valid, (k == 4)); end
      n_checks++; if (cmd_ready !== (k == 4)) begin n_fail++; $display("FAIL rst_settle_rdy tick%0d: got %b want %b", k, cmd_ready, (k == 4)); end
      n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL rst_settle_mode tick%0d: got %0d want 0", k, minor_mode); end
    end
  endtask

  task automatic test_mode_switch();
    goto_phase(10);
    issue(4'd1, 2'd0, 12'd0);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL sw1_pend_rdy: got %b want 0", cmd_ready); end
    goto_phase(0);
    n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL sw1_early: got %0d want 0", minor_mode); end
    step();
    n_checks++; if (minor_mode !== 4'd1) begin n_fail++; $display("FAIL sw1_mode: got %0d want 1", minor_mode); end
    n_checks++; if (mode_update !== 1'b1) begin n_fail++; $display("FAIL sw1_upd: got %b want 1", mode_update); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL sw1_rxv: got %b want 1", rx_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sw1_rdy: got %b want 1", cmd_ready); end
    step();
    n_checks++; if (mode_update !== 1'b0) begin n_fail++; $display("FAIL sw1_upd_pulse: got %b want 0", mode_update); end

    goto_phase(10);
    issue(4'd3, 2'd1, 12'd0);
    apply_tick();
    n_checks++; if (minor_mode !== 4'd3) begin n_fail++; $display("FAIL sw3_mode: got %0d want 3", minor_mode); end
    n_checks++; if (subcarrier_frequency !== 2'd1) begin n_fail++; $display("FAIL sw3_sub: got %0d want 1", subcarrier_frequency); end
    n_checks++; if (mode_update !== 1'b1) begin n_fail++; $display("FAIL sw3_upd: got %b want 1", mode_update); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL sw3_rxv: got %b want 0", rx_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL sw3_nosettle_rdy: got %b want 1", cmd_ready); end

    goto_phase(10);
    issue(4'd0, 2'd0, 12'd0);
    apply_tick();
    n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL sw0_mode: got %0d want 0", minor_mode); end
    n_checks++; if (subcarrier_frequency !== 2'd0) begin n_fail++; $display("FAIL sw0_sub: got %0d want 0", subcarrier_frequency); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL sw0_rxv: got %b want 0", rx_valid); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL sw0_rdy: got %b want 0", cmd_ready); end
    for (int k = 1; k <= 4; k++) begin
      apply_tick();
      n_checks++; if (rx_valid !== (k == 4)) begin n_fail++; $display("FAIL sw0_settle tick%0d: got %b want %b", k, rx_valid, (k == 4)); end
    end
  endtask

  task automatic test_tick_collision();
    goto_phase(0);
    issue(4'd1, 2'd2, 12'd0);
    n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL coll_mode: got %0d want 0", minor_mode); end
    n_checks++; if (mode_update !== 1'b0) begin n_fail++; $display("FAIL coll_upd: got %b want 0", mode_update); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL coll_rdy: got %b want 0", cmd_ready); end
    goto_phase(32);
    n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL coll_mid_mode: got %0d want 0", minor_mode); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL coll_mid_rdy: got %b want 0", cmd_ready); end
    apply_tick();
    n_checks++; if (minor_mode !== 4'd1) begin n_fail++; $display("FAIL coll_apply_mode: got %0d want 1", minor_mode); end
    n_checks++; if (subcarrier_frequency !== 2'd2) begin n_fail++; $display("FAIL coll_apply_sub: got %0d want 2", subcarrier_frequency); end
    n_checks++; if (mode_update !== 1'b1) begin n_fail++; $display("FAIL coll_apply_upd: got %b want 1", mode_update); end
  endtask

  task automatic test_jam();
    goto_phase(10);
    issue(4'd2, 2'd0, 12'd0);
    apply_tick();
    n_checks++; if (minor_mode !== 4'd2) begin n_fail++; $display("FAIL jam_pre_mode: got %0d want 2", minor_mode); end
    goto_phase(10);
    issue(4'd8, 2'd1, 12'd3);
    apply_tick();
    n_checks++; if (minor_mode !== 4'd8) begin n_fail++; $display("FAIL jam_mode: got %0d want 8", minor_mode); end
    n_checks++; if (mode_update !== 1'b1) begin n_fail++; $display("FAIL jam_upd: got %b want 1", mode_update); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL jam_rxv: got %b want 0", rx_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL jam_rdy: got %b want 1", cmd_ready); end
`ifdef HI_READER_JAM_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      apply_tick();
      if (k < 3) begin
        n_checks++; if (minor_mode !== 4'd8) begin n_fail++; $display("FAIL jam_hold tick%0d: got %0d want 8", k, minor_mode); end
        n_checks++; if (jam_done !== 1'b0) begin n_fail++; $display("FAIL jam_early_done tick%0d: got %b want 0", k, jam_done); end
      end else begin
        n_checks++; if (minor_mode !== 4'd2) begin n_fail++; $display("FAIL jam_restore_mode: got %0d want 2", minor_mode); end
        n_checks++; if (subcarrier_frequency !== 2'd0) begin n_fail++; $display("FAIL jam_restore_sub: got %0d want 0", subcarrier_frequency); end
        n_checks++; if (jam_done !== 1'b1) begin n_fail++; $display("FAIL jam_done: got %b want 1", jam_done); end
        n_checks++; if (mode_update !== 1'b1) begin n_fail++; $display("FAIL jam_done_upd: got %b want 1", mode_update); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL jam_settle_rdy: got %b want 0", cmd_ready); end
      end
    end
    step();
    n_checks++; if (jam_done !== 1'b0) begin n_fail++; $display("FAIL jam_done_pulse: got %b want 0", jam_done); end
`else
    for (int k = 1; k <= 100; k++) begin
      apply_tick();
      n_checks++; if (minor_mode !== 4'd8) begin n_fail++; $display("FAIL jam_persist tick%0d: got %0d want 8", k, minor_mode); end
      n_checks++; if (jam_done !== 1'b0) begin n_fail++; $display("FAIL jam_persist_done tick%0d: got %b want 0", k, jam_done); end
    end
    goto_phase(10);
    issue(4'd2, 2'd0, 12'd0);
    apply_tick();
    n_checks++; if (minor_mode !== 4'd2) begin n_fail++; $display("FAIL jam_back_mode: got %0d want 2", minor_mode); end
`endif
    for (int k = 1; k <= 4; k++) begin
      apply_tick();
      n_checks++; if (rx_valid !== (k == 4)) begin n_fail++; $display("FAIL jam_settle tick%0d: got %b want %b", k, rx_valid, (k == 4)); end
    end
  endtask

  task automatic test_jam_cancel();
    goto_phase(10);
    issue(4'd8, 2'd0, 12'd10);
    apply_tick();
    for (int k = 1; k <= 2; k++) begin
      apply_tick();
      n_checks++; if (minor_mode !== 4'd8) begin n_fail++; $display("FAIL cancel_hold tick%0d: got %0d want 8", k, minor_mode); end
    end
    goto_phase(10);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cancel_rdy_jam: got %b want 1", cmd_ready); end
    issue(4'd4, 2'd0, 12'd0);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL cancel_rdy_pend: got %b want 0", cmd_ready); end
    apply_tick();
    n_checks++; if (minor_mode !== 4'd4) begin n_fail++; $display("FAIL cancel_mode: got %0d want 4", minor_mode); end
    n_checks++; if (mode_update !== 1'b1) begin n_fail++; $display("FAIL cancel_upd: got %b want 1", mode_update); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cancel_rdy_run: got %b want 1", cmd_ready); end
    for (int k = 1; k <= 10; k++) begin
      apply_tick();
      n_checks++; if ({jam_done, minor_mode} !== {1'b0, 4'd4}) begin n_fail++; $display("FAIL cancel_after tick%0d: got done=%b mode=%0d want done=0 mode=4", k, jam_done, minor_mode); end
    end
  endtask

  task automatic test_illegal();
    goto_phase(10);
    issue(4'd12, 2'd1, 12'd0);
    n_checks++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", cmd_err); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ill_rdy: got %b want 1", cmd_ready); end
    step();
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL ill_err_pulse: got %b want 0", cmd_err); end
    apply_tick();
    n_checks++; if (minor_mode !== 4'd4) begin n_fail++; $display("FAIL ill_mode: got %0d want 4", minor_mode); end
    n_checks++; if (subcarrier_frequency !== 2'd0) begin n_fail++; $display("FAIL ill_sub: got %0d want 0", subcarrier_frequency); end
    n_checks++; if (mode_update !== 1'b0) begin n_fail++; $display("FAIL ill_upd: got %b want 0", mode_update); end
  endtask

  task automatic test_reset_pend();
    goto_phase(10);
    issue(4'd1, 2'd1, 12'd0);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rp_pend_rdy: got %b want 0", cmd_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (minor_mode !== 4'd0) begin n_fail++; $display("FAIL rp_mode: got %0d want 0", minor_mode); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rp_rxv: got %b want 0", rx_valid); end
    for (int k = 1; k <= 4; k++) begin
      apply_tick();
      n_checks++; if ({minor_mode, subcarrier_frequency, mode_update} !== 7'd0) begin n_fail++; $display("FAIL rp_lost tick%0d: got mode=%0d sub=%0d upd=%b want 0/0/0", k, minor_mode, subcarrier_frequency, mode_update); end
      n_checks++; if (rx_valid !== (k == 4)) begin n_fail++; $display("FAIL rp_settle tick%0d: got %b want %b", k, rx_valid, (k == 4)); end
    end
  endtask

  initial begin
    reset          = 1'b1;
    frame_tick     = 1'b0;
    cmd_valid      = 1'b0;
    cmd_mode       = 4'd0;
    cmd_subcarrier = 2'd0;
    cmd_frames     = 12'd0;
    test_reset();
    test_mode_switch();
    test_tick_collision();
    test_jam();
    test_jam_cancel();
    test_illegal();
    test_reset_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
